// File: rtl/mult_ctrl.sv
// mult_ctrl: controller between the EX stage and an iterative 32x32 multiplier.
// It issues the operands and then ignores a possibly stale ready flag for a
// fixed blanking window. It captures the signed product and corrects it for
// unsigned requests. Finally it writes the architectural HI/LO registers.
// While an operation is in flight, multiply and HI/LO accesses from the
// pipeline are stalled.
module mult_ctrl #(
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_start,
  input  logic        mult_ready,
  input  logic [63:0] mult_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // The counter must hold BLANK_CYCLES and still be at least one bit wide.
  localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BLANK = 3'd2,
    S_WAIT  = 3'd3,
    S_FIX   = 3'd4
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [31:0]     mult_a_reg;
  logic [31:0]     mult_b_reg;
  logic            mult_start_reg;
  logic            sgn_reg;
  logic [63:0]     prod_reg;
  logic [31:0]     hi_reg;
  logic [31:0]     lo_reg;
  logic            busy;

  // Unsigned correction terms: the multiplier returns a signed product. Any
  // operand whose top bit is set was seen as negative. The other operand must
  // then be added back into the upper word.
  logic [31:0]     corr_a;
  logic [31:0]     corr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_corr
      assign corr_a[gi] = mult_a_reg[31] & mult_b_reg[gi];
      assign corr_b[gi] = mult_b_reg[31] & mult_a_reg[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = (BLANK_CYCLES == 0) ? S_WAIT : S_BLANK;
      end
      S_BLANK: begin
        // The counter is on its final count, so the window closes this cycle.
        if (cnt_reg <= CW'(1)) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mult_ready) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: operand latch, start pulse, blank counter, product, HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      mult_start_reg <= 1'b0;
      mult_a_reg     <= '0;
      mult_b_reg     <= '0;
      sgn_reg        <= 1'b0;
      cnt_reg        <= '0;
      prod_reg       <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
    end else begin
      // Registered so that the pulse is high exactly during the START cycle.
      mult_start_reg <= (state_next == S_START);
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            mult_a_reg <= req_a;
            mult_b_reg <= req_b;
            sgn_reg    <= req_signed;
          end
        end
        S_START: begin
          cnt_reg <= CW'(BLANK_CYCLES);
        end
        S_BLANK: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_WAIT: begin
          if (mult_ready) begin
            prod_reg <= mult_out;
          end
        end
        S_FIX: begin
          lo_reg <= prod_reg[31:0];
          if (sgn_reg) begin
            hi_reg <= prod_reg[63:32];
          end else begin
            hi_reg <= prod_reg[63:32] + corr_a + corr_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: interlock and HI/LO read port, both combinational.
  always_comb begin
    busy    = (state_reg != S_IDLE);
    stall   = 1'b0;
    rd_data = '0;
    if (!reset) begin
      stall = busy & (req_valid | mfhi_req | mflo_req);
      if (mfhi_req) begin
        rd_data = hi_reg;
      end else if (mflo_req) begin
        rd_data = lo_reg;
      end
    end
  end

  assign mult_a     = mult_a_reg;
  assign mult_b     = mult_b_reg;
  assign mult_start = mult_start_reg;
  assign hi         = hi_reg;
  assign lo         = lo_reg;

endmodule
